// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO multiply/divide unit: shift-add multiply, restoring divide, 32 iterations, result on edge N+32.
// No backpressure: start/mthi/mtlo are dropped outside IDLE; busy flags the iteration window.
module mips_cpu_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_lo;
  logic        neg_hi;
  logic        div0;
  logic [63:0] acc;
  logic [31:0] opb;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] msum, rshift, rdiff;
  logic [63:0] acc_next, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Magnitudes are only taken for the signed ops; unsigned ops use raw operands.
  always_comb begin
    a_neg = ~op[0] & a[31];
    b_neg = ~op[0] & b[31];
    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;
  end

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    msum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    rshift = {acc[63:32], acc[31]};
    rdiff  = rshift - {1'b0, opb};
    if (is_div) begin
      if (rdiff[32])
        acc_next = {rshift[31:0], acc[30:0], 1'b0};
      else
        acc_next = {rdiff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_next = {msum, acc[31:1]};
    end
    prod_fix = neg_lo ? (64'd0 - acc_next) : acc_next;
    quo_fix  = neg_lo ? (32'd0 - acc_next[31:0]) : acc_next[31:0];
    rem_fix  = neg_hi ? (32'd0 - acc_next[63:32]) : acc_next[63:32];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      acc    <= 64'd0;
      opb    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            cnt    <= 5'd0;
            is_div <= op[1];
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= op[1] ? a_neg : (a_neg ^ b_neg);
            div0   <= op[1] & (b == 32'd0);
            acc    <= {32'd0, a_mag};
            opb    <= b_mag;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The last iteration's result is sign-corrected and written on the same edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (state == RUN && cnt == 5'd31) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= div0 ? 32'hFFFF_FFFF : quo_fix;
      end else begin
        hi <= prod_fix[63:32];
        lo <= prod_fix[31:0];
      end
    end else if (state == IDLE && !start) begin
      if (mthi)
        hi <= wdata;
      if (mtlo)
        lo <= wdata;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Bench for mips_cpu_muldiv: directed vector table, hand-written corner sequences, random ops vs arithmetic model.
module tb_mips_cpu_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mips_cpu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Plain-arithmetic model of the architectural HI/LO result, returned as {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, m;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: r = 64'(sx * sy);
      2'd1: r = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // Issues one op; operand inputs are scrambled right after the start edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic wm,
                       output logic [31:0] rh, output logic [31:0] rl, output logic [31:0] hi_after_start,
                       output int lat, output int bc);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1; mthi = wm; wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    hi_after_start = hi;
    start = 1'b0; mthi = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 1; bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    rh = hi;
    rl = lo;
  endtask

  task automatic check_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic wm, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] rh, rl, h1;
    int lat, bc;
    do_op(o, x, y, wm, rh, rl, h1, lat, bc);
    chk({nm, ".latency"}, 64'(lat), 64'd33);
    chk({nm, ".busy_cycles"}, 64'(bc), 64'd32);
    chk({nm, ".hi"}, {32'd0, rh}, {32'd0, eh});
    chk({nm, ".lo"}, {32'd0, rl}, {32'd0, el});
    @(negedge clk);
    chk({nm, ".done_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] rh, rl, h1, h0, l0;
    logic [63:0] expv;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int lat, bc, k;
    logic saw_done;

    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{2'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9] = '{2'd1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};

    reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
    #3;
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.done", {63'd0, done}, 64'd0);
    chk("reset.hi", {32'd0, hi}, 64'd0);
    chk("reset.lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp_hi, vecs[i].exp_lo);

    // MTLO alone, then MTHI+MTLO together
    @(negedge clk);
    h0 = hi;
    mtlo = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo.lo", {32'd0, lo}, 64'h1234_5678);
    chk("mtlo.hi_kept", {32'd0, hi}, {32'd0, h0});
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo.hi", {32'd0, hi}, 64'hCAFE_F00D);
    chk("mthilo.lo", {32'd0, lo}, 64'hCAFE_F00D);

    // second start plus MTHI/MTLO held through RUN and DONE
    h0 = hi; l0 = lo;
    op = 2'd1; a = 32'd6; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 5) begin
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd3;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (lat == 10) begin
        chk("ignore.hi_hold", {32'd0, hi}, {32'd0, h0});
        chk("ignore.lo_hold", {32'd0, lo}, {32'd0, l0});
      end
      @(negedge clk);
      lat++;
    end
    chk("ignore.latency", 64'(lat), 64'd33);
    chk("ignore.hi", {32'd0, hi}, 64'd0);
    chk("ignore.lo", {32'd0, lo}, 64'h36);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    chk("ignore.no_restart", {62'd0, busy, done}, 64'd0);
    chk("ignore.lo_after", {32'd0, lo}, 64'h36);

    // reset in the middle of RUN
    op = 2'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrst.busy_before", {63'd0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst.busy", {63'd0, busy}, 64'd0);
    chk("midrst.done", {63'd0, done}, 64'd0);
    chk("midrst.hi", {32'd0, hi}, 64'd0);
    chk("midrst.lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("midrst.no_done", {63'd0, saw_done}, 64'd0);
    check_op("after_rst", 2'd1, 32'd6, 32'd7, 1'b0, 32'd0, 32'h2A);

    // start and MTHI in the same IDLE cycle
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h1111_1111;
    @(negedge clk);
    mthi = 1'b0;
    do_op(2'd1, 32'd2, 32'd3, 1'b1, rh, rl, h1, lat, bc);
    chk("start_mthi.hi_not_written", {32'd0, h1}, 64'h1111_1111);
    chk("start_mthi.latency", 64'(lat), 64'd33);
    chk("start_mthi.hi", {32'd0, rh}, 64'd0);
    chk("start_mthi.lo", {32'd0, rl}, 64'd6);

    // random operations against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      k  = $urandom_range(0, 7);
      ra = (k == 7) ? 32'h8000_0000 : $urandom;
      case (k)
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'd0 - 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      expv = ref_model(ro, ra, rb);
      check_op($sformatf("rand%0d op%0d a=%h b=%h", i, ro, ra, rb), ro, ra, rb, 1'b0, expv[63:32], expv[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
